// File: rtl/alu_pkg.sv
// alu_pkg: opcode codes and issue FSM states shared by the ALU issue controller.
package alu_pkg;
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_INCR = 4'd3;
  localparam logic [3:0] OP_DECR = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_NOT  = 4'd8;
  localparam logic [3:0] OP_NAND = 4'd9;
  localparam logic [3:0] OP_NOR  = 4'd10;
  localparam logic [3:0] OP_XNOR = 4'd11;
  localparam logic [3:0] OP_RSH  = 4'd12;
  localparam logic [3:0] OP_LSH  = 4'd13;
  localparam logic [3:0] OP_RRSH = 4'd14;
  localparam logic [3:0] OP_LLSH = 4'd15;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; ptr picks the winner only on contention.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);
  assign grant = &valid ? (ptr ? 2'b10 : 2'b01) : valid;
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: arbitrates two requesters onto one shared ALU and registers its response.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int W       = 32,
  parameter int ALU_LAT = 1,
  parameter int MUL_LAT = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [7:0]     req_opcode,
  input  logic [2*W-1:0] req_op1,
  input  logic [2*W-1:0] req_op2,
  output logic [3:0]     alu_opcode,
  output logic [W-1:0]   alu_operand1,
  output logic [W-1:0]   alu_operand2,
  input  logic [W-1:0]   alu_result,
  input  logic           alu_carry,
  input  logic [2*W-1:0] alu_product,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [W-1:0]   rsp_result,
  output logic           rsp_carry,
  output logic [2*W-1:0] rsp_product,
  output logic           busy
);
  localparam int CW = $clog2((MUL_LAT > ALU_LAT ? MUL_LAT : ALU_LAT) + 1);
  state_t          state;
  logic [CW-1:0]   cnt;
  logic            rr_ptr;
  logic [1:0]      grant;
  logic            sel;
  logic [3:0]      sel_op;
  logic [W-1:0]    sel_a, sel_b;
  logic            is_mul, is_arith;
  logic [W-1:0]    cap_result;
  logic            cap_carry;
  logic [2*W-1:0]  cap_product;
  rr_arb2 u_arb (.valid(req_valid), .ptr(rr_ptr), .grant(grant));
  assign req_ready   = state == IDLE ? grant : 2'b00;
  assign busy        = state != IDLE;
  assign sel         = grant[1];
  assign sel_op      = sel ? req_opcode[7:4] : req_opcode[3:0];
  assign sel_a       = sel ? req_op1[2*W-1:W] : req_op1[W-1:0];
  assign sel_b       = sel ? req_op2[2*W-1:W] : req_op2[W-1:0];
  assign is_mul      = alu_opcode == OP_MUL;
  assign is_arith    = alu_opcode inside {OP_ADD, OP_SUB, OP_INCR, OP_DECR};
  // MUL reports through the product bus; logic/shift ops never expose a carry
  assign cap_result  = is_mul ? alu_product[W-1:0] : alu_result;
  assign cap_carry   = is_mul ? |alu_product[2*W-1:W] : is_arith & alu_carry;
  assign cap_product = is_mul ? alu_product : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      rr_ptr       <= 1'b0;
      alu_opcode   <= '0;
      alu_operand1 <= '0;
      alu_operand2 <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_carry    <= 1'b0;
      rsp_product  <= '0;
    end else begin
      case (state)
        IDLE: if (|req_ready) begin
          alu_opcode   <= sel_op;
          alu_operand1 <= sel_a;
          alu_operand2 <= sel_b;
          rsp_id       <= sel;
          rr_ptr       <= ~sel;
          cnt          <= sel_op == OP_MUL ? CW'(MUL_LAT - 1) : CW'(ALU_LAT - 1);
          state        <= EXEC;
        end
        EXEC: if (cnt == '0) begin
          rsp_result  <= cap_result;
          rsp_carry   <= cap_carry;
          rsp_product <= cap_product;
          rsp_valid   <= 1'b1;
          state       <= RESP;
        end else begin
          cnt <= cnt - 1'b1;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: random and directed traffic against a transaction-level model of the issue controller.
module tb_alu_issue_ctrl;
  localparam int W = 32;
  localparam int ALU_LAT = 1;
  localparam int MUL_LAT = 4;
  logic           clk = 0;
  logic           rst;
  logic [1:0]     req_valid, req_ready;
  logic [7:0]     req_opcode;
  logic [2*W-1:0] req_op1, req_op2;
  logic [3:0]     alu_opcode;
  logic [W-1:0]   alu_operand1, alu_operand2, alu_result;
  logic           alu_carry;
  logic [2*W-1:0] alu_product;
  logic           rsp_valid, rsp_ready, rsp_id, rsp_carry, busy;
  logic [W-1:0]   rsp_result;
  logic [2*W-1:0] rsp_product;
  int tests = 0, fails = 0;
  int cyc = 0;
  logic [W-1:0] junk_w;
  logic         junk_c, force_c = 0;
  bit           m_busy = 0, m_ptr = 0, m_id = 0;
  int           m_due = 0;
  logic [W-1:0] m_res;
  logic         m_c;
  logic [63:0]  m_prod;
  int           acc_id[$];
  int           acc_cyc[$];
  alu_issue_ctrl #(.W(W), .ALU_LAT(ALU_LAT), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_op1(req_op1), .req_op2(req_op2),
    .alu_opcode(alu_opcode), .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_product(alu_product),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_product(rsp_product), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [W-1:0] logic_fn(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      4'd5: return a & b;
      4'd6: return a | b;
      4'd7: return a ^ b;
      4'd8: return ~a;
      default: return a >> b[4:0];
    endcase
  endfunction
  // Stand-in ALU: arithmetic carries are real, everything else drives garbage on unused outputs
  always_comb begin
    alu_product = '0;
    alu_result  = logic_fn(alu_opcode, alu_operand1, alu_operand2);
    alu_carry   = junk_c;
    case (alu_opcode)
      4'd0: {alu_carry, alu_result} = {1'b0, alu_operand1} + {1'b0, alu_operand2};
      4'd1: {alu_carry, alu_result} = {1'b0, alu_operand1} - {1'b0, alu_operand2};
      4'd2: begin
        alu_product = {{W{1'b0}}, alu_operand1} * {{W{1'b0}}, alu_operand2};
        alu_result  = junk_w;
      end
      4'd3: {alu_carry, alu_result} = {1'b0, alu_operand1} + 33'd1;
      4'd4: {alu_carry, alu_result} = {1'b0, alu_operand1} - 33'd1;
      default: ;
    endcase
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic set_req(input int n, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    req_opcode[n*4 +: 4] = op;
    req_op1[n*W +: W]    = a;
    req_op2[n*W +: W]    = b;
  endtask
  task automatic expect_of(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] s;
    m_prod = 0;
    m_c = 0;
    if (op == 4'd2) begin
      m_prod = a * b; m_res = m_prod[W-1:0]; m_c = m_prod >= 64'h1_0000_0000;
    end else if (op == 4'd0) begin
      s = a + b; m_res = s[W-1:0]; m_c = s > 64'hFFFF_FFFF;
    end else if (op == 4'd1) begin
      s = a - b; m_res = s[W-1:0]; m_c = a < b;
    end else if (op == 4'd3) begin
      s = a + 1; m_res = s[W-1:0]; m_c = a == 64'hFFFF_FFFF;
    end else if (op == 4'd4) begin
      s = a - 1; m_res = s[W-1:0]; m_c = a == 0;
    end else m_res = logic_fn(op, a[W-1:0], b[W-1:0]);
  endtask
  // One clock: drive at the falling edge, compare against the model, then advance it past the rising edge
  task automatic step(input logic [1:0] v, input logic rr);
    logic [1:0] eg;
    bit ev;
    int n;
    req_valid = v;
    rsp_ready = rr;
    junk_w = $urandom;
    junk_c = force_c ? 1'b1 : 1'($urandom);
    #1;
    eg = m_busy ? 2'b00 : (&v ? (m_ptr ? 2'b10 : 2'b01) : v);
    ev = m_busy && cyc >= m_due;
    check("req_ready", 64'(req_ready), 64'(eg));
    check("busy", 64'(busy), 64'(m_busy));
    check("rsp_valid", 64'(rsp_valid), 64'(ev));
    if (ev) begin
      check("rsp_id", 64'(rsp_id), 64'(m_id));
      check("rsp_result", 64'(rsp_result), 64'(m_res));
      check("rsp_carry", 64'(rsp_carry), 64'(m_c));
      check("rsp_product", rsp_product, m_prod);
    end
    if (|(req_valid & req_ready)) begin
      acc_id.push_back(int'(req_ready[1]));
      acc_cyc.push_back(cyc);
    end
    if (!m_busy && |eg) begin
      n = int'(eg[1]);
      expect_of(req_opcode[n*4 +: 4], 64'(req_op1[n*W +: W]), 64'(req_op2[n*W +: W]));
      m_busy = 1;
      m_id = eg[1];
      m_ptr = ~eg[1];
      m_due = cyc + 1 + (req_opcode[n*4 +: 4] == 4'd2 ? MUL_LAT : ALU_LAT);
    end else if (ev && rr) m_busy = 0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask
  initial begin
    int base, n0;
    rst = 1;
    req_valid = 0; rsp_ready = 0; req_opcode = 0; req_op1 = 0; req_op2 = 0;
    junk_w = 0; junk_c = 0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 0);
    check("rst_rsp_valid", 64'(rsp_valid), 0);
    check("rst_rsp_product", rsp_product, 0);
    check("rst_alu_opcode", 64'(alu_opcode), 0);
    rst = 0;
    // ADD wrap-around from requester 0
    set_req(0, 4'd0, 32'hFFFF_FFFF, 32'h1);
    step(2'b01, 1); step(2'b00, 1); step(2'b00, 1);
    // MUL from requester 1 with a carry into the upper half
    set_req(1, 4'd2, 32'h0001_0000, 32'h0001_0000);
    step(2'b10, 1);
    repeat (5) step(2'b00, 1);
    // Continuous contention: grants alternate, one IDLE bubble between ops
    set_req(0, 4'd1, 32'h5, 32'h9);
    set_req(1, 4'd3, 32'h7, 32'h0);
    base = acc_id.size();
    repeat (12) step(2'b11, 1);
    check("alt_count", 64'(acc_id.size() - base), 4);
    for (int i = base + 1; i < acc_id.size(); i++) begin
      check("alt_id", 64'(acc_id[i]), 64'(acc_id[i-1] ^ 1));
      check("alt_interval", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'(ALU_LAT + 2));
    end
    repeat (2) step(2'b00, 1);
    // Stalled consumer: response held, nothing new accepted
    set_req(0, 4'd4, 32'h0, 32'h0);
    step(2'b01, 0);
    n0 = acc_id.size();
    repeat (12) step(2'b11, 0);
    check("stall_accepts", 64'(acc_id.size() - n0), 0);
    step(2'b11, 1); step(2'b11, 1); step(2'b00, 1);
    check("release_accepts", 64'(acc_id.size() - n0), 1);
    repeat (3) step(2'b00, 1);
    // XOR must drop whatever carry the ALU reports
    force_c = 1;
    set_req(0, 4'd7, 32'hF0F0_F0F0, 32'hFFFF_0000);
    step(2'b01, 1); step(2'b00, 1); step(2'b00, 1);
    force_c = 0;
    // Reset in the middle of a MUL
    set_req(1, 4'd2, 32'h1234, 32'h5678);
    step(2'b10, 1); step(2'b00, 1);
    req_valid = 0;
    rst = 1;
    #1;
    check("midrst_busy", 64'(busy), 0);
    check("midrst_rsp_valid", 64'(rsp_valid), 0);
    check("midrst_req_ready", 64'(req_ready), 0);
    @(negedge clk);
    rst = 0;
    m_busy = 0; m_ptr = 0;
    repeat (6) step(2'b00, 1);
    // Random traffic
    for (int i = 0; i < 600; i++) begin
      for (int r = 0; r < 2; r++)
        if ($urandom_range(3) == 0)
          set_req(r, 4'($urandom), ($urandom_range(3) == 0) ? 32'hFFFF_FFFF : $urandom,
                  ($urandom_range(3) == 0) ? 32'h0 : $urandom);
      step(2'($urandom), $urandom_range(3) != 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
